wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_if.sv | 36 +++
 rtl/wb_stage.sv | 66 ++++++
 tb/tb_wb_stage.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM/WB boundary bundle.
//   EX/MEM side (driven by master): ex_mem_wb_ctl {regwrite, memtoreg}, ex_mem_rd,
//     ex_mem_alu_result, mem_read_data, ex_mem_valid, stall, flush.
//   Write-back side (driven by slave): MEM_WB_rd, MEM_WB_regwrite,
//     WB_mux_writedata, mem_wb_valid, retire_count.
interface wb_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic [1:0]        ex_mem_wb_ctl;
  logic [4:0]        ex_mem_rd;
  logic [DATA_W-1:0] ex_mem_alu_result;
  logic [DATA_W-1:0] mem_read_data;
  logic              ex_mem_valid;
  logic              stall;
  logic              flush;

  logic [4:0]        MEM_WB_rd;
  logic              MEM_WB_regwrite;
  logic [DATA_W-1:0] WB_mux_writedata;
  logic              mem_wb_valid;
  logic [DATA_W-1:0] retire_count;

  modport master (
    output ex_mem_wb_ctl, ex_mem_rd, ex_mem_alu_result, mem_read_data,
           ex_mem_valid, stall, flush,
    input  MEM_WB_rd, MEM_WB_regwrite, WB_mux_writedata, mem_wb_valid,
           retire_count
  );

  modport slave (
    input  ex_mem_wb_ctl, ex_mem_rd, ex_mem_alu_result, mem_read_data,
           ex_mem_valid, stall, flush,
    output MEM_WB_rd, MEM_WB_regwrite, WB_mux_writedata, mem_wb_valid,
           retire_count
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register plus write-back mux and retire counter.
//   clk    : single clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : wb_stage_if.slave (EX/MEM inputs, stall/flush, write-back outputs)
// Priority on each edge: reset > flush > stall > load.
module wb_stage #(
  parameter int unsigned DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  wb_stage_if.slave  bus
);

  logic              valid_q;
  logic              regwrite_q;
  logic              memtoreg_q;
  logic [4:0]        rd_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] retire_q;
  logic              retire_now;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      rd_q       <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
    end else if (bus.flush) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      rd_q       <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
    end else if (!bus.stall) begin
      valid_q    <= bus.ex_mem_valid;
      regwrite_q <= bus.ex_mem_wb_ctl[1] & bus.ex_mem_valid;
      memtoreg_q <= bus.ex_mem_wb_ctl[0];
      rd_q       <= bus.ex_mem_rd;
      alu_q      <= bus.ex_mem_alu_result;
      rdata_q    <= bus.mem_read_data;
    end
  end

  // An instruction leaves write-back whenever the register is not holding it;
  // flush overrides stall, so a flushed-while-stalled instruction still retires.
  assign retire_now = valid_q & (bus.flush | ~bus.stall);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retire_q <= '0;
    end else if (retire_now) begin
      retire_q <= retire_q + DATA_W'(1);
    end
  end

  assign bus.MEM_WB_rd        = rd_q;
  assign bus.MEM_WB_regwrite  = regwrite_q & valid_q & (rd_q != 5'd0);
  assign bus.WB_mux_writedata = memtoreg_q ? rdata_q : alu_q;
  assign bus.mem_wb_valid     = valid_q;
  assign bus.retire_count     = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic clk;
  logic rst_n;

  wb_stage_if #(.DATA_W(32)) bus ();

  wb_stage #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] count;
  } exp_t;

  exp_t exp_q[$];

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Reference MEM/WB state
  logic        m_valid, m_rw, m_mtr;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_rdat, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle at negedge, push expectation, let the edge happen, then compare.
  task automatic step(input logic r, input logic v, input logic [1:0] ctl,
                      input logic [4:0] rd, input logic [31:0] alu,
                      input logic [31:0] rdat, input logic st, input logic fl);
    exp_t e;
    exp_t got;
    rst_n                 = r;
    bus.ex_mem_valid      = v;
    bus.ex_mem_wb_ctl     = ctl;
    bus.ex_mem_rd         = rd;
    bus.ex_mem_alu_result = alu;
    bus.mem_read_data     = rdat;
    bus.stall             = st;
    bus.flush             = fl;
    if (!r) begin
      {m_valid, m_rw, m_mtr} = 3'b000;
      m_rd = '0; m_alu = '0; m_rdat = '0; m_cnt = '0;
    end else begin
      if (m_valid && (fl || !st)) m_cnt = m_cnt + 32'd1;
      if (fl) begin
        {m_valid, m_rw, m_mtr} = 3'b000;
        m_rd = '0; m_alu = '0; m_rdat = '0;
      end else if (!st) begin
        m_valid = v;
        m_rw    = ctl[1] & v;
        m_mtr   = ctl[0];
        m_rd    = rd;
        m_alu   = alu;
        m_rdat  = rdat;
      end
    end
    e.valid    = m_valid;
    e.regwrite = m_rw & m_valid & (m_rd != 5'd0);
    e.rd       = m_rd;
    e.wdata    = m_mtr ? m_rdat : m_alu;
    e.count    = m_cnt;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      got = exp_q.pop_front();
      chk("valid",    {31'd0, bus.mem_wb_valid},    {31'd0, got.valid});
      chk("regwrite", {31'd0, bus.MEM_WB_regwrite}, {31'd0, got.regwrite});
      chk("rd",       {27'd0, bus.MEM_WB_rd},       {27'd0, got.rd});
      chk("wdata",    bus.WB_mux_writedata,         got.wdata);
      chk("count",    bus.retire_count,             got.count);
    end
  endtask

  initial begin
    m_cnt = '0; m_valid = 1'b0; m_rw = 1'b0; m_mtr = 1'b0;
    m_rd = '0; m_alu = '0; m_rdat = '0;
    @(negedge clk);

    // Reset
    step(0, 1, 2'b11, 5'd7, 32'h1234, 32'h5678, 0, 0);
    step(0, 1, 2'b11, 5'd7, 32'h1234, 32'h5678, 1, 1);
    chk("rst_valid", {31'd0, bus.mem_wb_valid}, 32'd0);
    chk("rst_wdata", bus.WB_mux_writedata, 32'd0);
    chk("rst_count", bus.retire_count, 32'd0);

    // R-type, first load on first rst_n=1 edge
    step(1, 1, 2'b10, 5'd8, 32'h30, 32'hAAAA, 0, 0);
    chk("rtype_regwrite", {31'd0, bus.MEM_WB_regwrite}, 32'd1);
    chk("rtype_rd", {27'd0, bus.MEM_WB_rd}, 32'd8);
    chk("rtype_wdata", bus.WB_mux_writedata, 32'h30);
    chk("rtype_count_before", bus.retire_count, 32'd0);

    // Load; the R-type retires on this edge
    step(1, 1, 2'b11, 5'd9, 32'h100, 32'hDEADBEEF, 0, 0);
    chk("rtype_count_after", bus.retire_count, 32'd1);
    chk("load_wdata", bus.WB_mux_writedata, 32'hDEADBEEF);
    chk("load_regwrite", {31'd0, bus.MEM_WB_regwrite}, 32'd1);

    // Write to $0
    step(1, 1, 2'b10, 5'd0, 32'h55, 32'h0, 0, 0);
    chk("r0_regwrite", {31'd0, bus.MEM_WB_regwrite}, 32'd0);
    chk("r0_valid", {31'd0, bus.mem_wb_valid}, 32'd1);

    // Store-like (no regwrite), then a bubble carrying regwrite control
    step(1, 1, 2'b01, 5'd4, 32'h44, 32'h4444, 0, 0);
    chk("r0_counted", bus.retire_count, 32'd3);
    step(1, 0, 2'b10, 5'd7, 32'h77, 32'h7777, 0, 0);
    chk("bubble_regwrite", {31'd0, bus.MEM_WB_regwrite}, 32'd0);
    step(1, 0, 2'b00, 5'd0, 32'h0, 32'h0, 0, 0);
    chk("bubble_not_counted", bus.retire_count, 32'd4);

    // Stall three cycles on rd=5 while inputs change
    step(1, 1, 2'b10, 5'd5, 32'h505, 32'h0, 0, 0);
    step(1, 1, 2'b11, 5'd20, 32'h1, 32'h2, 1, 0);
    step(1, 1, 2'b10, 5'd21, 32'h3, 32'h4, 1, 0);
    step(1, 0, 2'b01, 5'd22, 32'h5, 32'h6, 1, 0);
    chk("stall_rd", {27'd0, bus.MEM_WB_rd}, 32'd5);
    chk("stall_wdata", bus.WB_mux_writedata, 32'h505);
    chk("stall_count", bus.retire_count, 32'd4);
    step(1, 0, 2'b00, 5'd0, 32'h0, 32'h0, 0, 0);
    chk("stall_release_count", bus.retire_count, 32'd5);

    // Flush and stall together on a held valid instruction
    step(1, 1, 2'b10, 5'd12, 32'hC0, 32'h0, 0, 0);
    step(1, 1, 2'b10, 5'd13, 32'hD0, 32'h0, 1, 0);
    step(1, 1, 2'b10, 5'd14, 32'hE0, 32'h0, 1, 1);
    chk("flush_valid", {31'd0, bus.mem_wb_valid}, 32'd0);
    chk("flush_regwrite", {31'd0, bus.MEM_WB_regwrite}, 32'd0);
    chk("flush_count", bus.retire_count, 32'd6);
    step(1, 1, 2'b11, 5'd15, 32'hF0, 32'hF1, 0, 1);
    step(1, 0, 2'b00, 5'd0, 32'h0, 32'h0, 0, 0);
    chk("flush_bubble_not_counted", bus.retire_count, 32'd6);

    // Counter wrap from all-ones
    step(1, 1, 2'b10, 5'd3, 32'h33, 32'h0, 0, 0);
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    m_cnt = 32'hFFFF_FFFF;
    chk("preload", bus.retire_count, 32'hFFFF_FFFF);
    step(1, 1, 2'b10, 5'd6, 32'h66, 32'h0, 0, 0);
    chk("wrap", bus.retire_count, 32'h0);

    // Reset mid-stall discards the held instruction
    step(1, 1, 2'b10, 5'd10, 32'hA0, 32'h0, 1, 0);
    step(0, 1, 2'b10, 5'd11, 32'hB0, 32'h0, 1, 0);
    chk("rst_stall_rd", {27'd0, bus.MEM_WB_rd}, 32'd0);
    chk("rst_stall_count", bus.retire_count, 32'd0);
    step(1, 0, 2'b00, 5'd0, 32'h0, 32'h0, 0, 0);
    chk("rst_stall_not_counted", bus.retire_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
